// File: rtl/regfile_wb_sched_if.sv
// Write-port bus of the register-file writeback scheduler: port A and port B
// write requests plus the registered write to the register file.
interface regfile_wb_sched_if;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        b_ready;
   logic        wr_we;
   logic [4:0]  wr_rd;
   logic [31:0] wr_data;

   modport master (
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  a_ready, b_ready, wr_we, wr_rd, wr_data
   );

   modport slave (
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output a_ready, b_ready, wr_we, wr_rd, wr_data
   );
endinterface

// File: rtl/regfile_wb_sched.sv
// Register-file write-port arbiter (A priority, B anti-starvation) with a busy
// scoreboard for B results. Define WB_FWD_EN to forward the in-flight write.
module regfile_wb_sched #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   regfile_wb_sched_if.slave         bus,
   input  logic                      i_b_issue,
   input  logic [4:0]                i_b_issue_rd,
   input  logic [4:0]                i_rs,
   input  logic [4:0]                i_rt,
   output logic                      o_hazard,
   output logic                      o_fwd_a_hit,
   output logic                      o_fwd_b_hit,
   output logic [31:0]               o_fwd_data
);

   logic [3:0]  r_starve_cnt;
   logic [31:0] r_busy;
   logic [31:0] w_busy_nxt;
   logic        w_force_b;
   logic        w_busy_hit;
   logic        w_rs_match;
   logic        w_rt_match;

   // B is forced through once it has waited STARVE_MAX consecutive cycles
   assign w_force_b   = bus.b_valid && (r_starve_cnt == STARVE_MAX[3:0]);
   assign bus.a_ready = bus.a_valid && !w_force_b;
   assign bus.b_ready = bus.b_valid && (w_force_b || !bus.a_valid);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_starve_cnt <= '0;
      end else if (!bus.b_valid || bus.b_ready) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != STARVE_MAX[3:0]) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         bus.wr_we   <= 1'b0;
         bus.wr_rd   <= '0;
         bus.wr_data <= '0;
      end else if (bus.a_ready) begin
         bus.wr_we   <= (bus.a_rd != 5'd0);
         bus.wr_rd   <= bus.a_rd;
         bus.wr_data <= bus.a_data;
      end else if (bus.b_ready) begin
         bus.wr_we   <= (bus.b_rd != 5'd0);
         bus.wr_rd   <= bus.b_rd;
         bus.wr_data <= bus.b_data;
      end else begin
         bus.wr_we   <= 1'b0;
      end
   end

   // Set is applied after clear so a same-cycle issue to the same register wins
   always_comb begin
      w_busy_nxt = r_busy;
      if (bus.b_ready && (bus.b_rd != 5'd0)) begin
         w_busy_nxt[bus.b_rd] = 1'b0;
      end
      if (i_b_issue && (i_b_issue_rd != 5'd0)) begin
         w_busy_nxt[i_b_issue_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign w_busy_hit = ((i_rs != 5'd0) && r_busy[i_rs]) ||
                       ((i_rt != 5'd0) && r_busy[i_rt]);
   assign w_rs_match = bus.wr_we && (bus.wr_rd == i_rs) && (i_rs != 5'd0);
   assign w_rt_match = bus.wr_we && (bus.wr_rd == i_rt) && (i_rt != 5'd0);

`ifdef WB_FWD_EN
   assign o_hazard    = w_busy_hit;
   assign o_fwd_a_hit = w_rs_match;
   assign o_fwd_b_hit = w_rt_match;
   assign o_fwd_data  = bus.wr_data;
`else
   assign o_hazard    = w_busy_hit || w_rs_match || w_rt_match;
   assign o_fwd_a_hit = 1'b0;
   assign o_fwd_b_hit = 1'b0;
   assign o_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched (arbitration, starvation,
// scoreboard, zero register, reset). Honours WB_FWD_EN for expected values.
module tb_regfile_wb_sched;

   logic        clk;
   logic        rst;
   logic        b_issue;
   logic [4:0]  b_issue_rd;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        hazard;
   logic        fwd_a_hit;
   logic        fwd_b_hit;
   logic [31:0] fwd_data;

   int unsigned n_cmp;
   int unsigned n_err;

   regfile_wb_sched_if bus ();

   regfile_wb_sched #(.STARVE_MAX(4)) u_dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .bus          (bus),
      .i_b_issue    (b_issue),
      .i_b_issue_rd (b_issue_rd),
      .i_rs         (rs),
      .i_rt         (rt),
      .o_hazard     (hazard),
      .o_fwd_a_hit  (fwd_a_hit),
      .o_fwd_b_hit  (fwd_b_hit),
      .o_fwd_data   (fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the posedge; checks happen on the negedge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

`ifdef WB_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      b_issue = 1'b0;
      b_issue_rd = '0;
      rs = '0;
      rt = '0;
      bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
      next_cycle();
      next_cycle();

      // reset then idle
      rst = 1'b0; rs = 5'd5; rt = 5'd6;
      @(negedge clk);
      check("rst_wr_we",   32'(bus.wr_we), 32'd0);
      check("rst_wr_rd",   32'(bus.wr_rd), 32'd0);
      check("rst_wr_data", bus.wr_data, 32'd0);
      check("rst_hazard",  32'(hazard), 32'd0);
      check("rst_fwd_a",   32'(fwd_a_hit), 32'd0);
      check("rst_a_ready", 32'(bus.a_ready), 32'd0);

      // single A write
      next_cycle();
      bus.a_valid = 1'b1; bus.a_rd = 5'd8; bus.a_data = 32'hDEADBEEF;
      @(negedge clk);
      check("a1_a_ready", 32'(bus.a_ready), 32'd1);
      check("a1_b_ready", 32'(bus.b_ready), 32'd0);
      next_cycle();
      bus.a_valid = 1'b0;
      @(negedge clk);
      check("a1_wr_we",   32'(bus.wr_we), 32'd1);
      check("a1_wr_rd",   32'(bus.wr_rd), 32'd8);
      check("a1_wr_data", bus.wr_data, 32'hDEADBEEF);
      next_cycle();
      @(negedge clk);
      check("a1_idle_we", 32'(bus.wr_we), 32'd0);
      check("a1_hold_rd", 32'(bus.wr_rd), 32'd8);

      // starvation: A and B both held from cycle 0, B forced in cycle 4
      next_cycle();
      bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'h0000_0011;
      bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h0000_0099;
      for (int c = 0; c < 5; c++) begin
         if (c != 0) next_cycle();
         @(negedge clk);
         check($sformatf("starve_b_ready_c%0d", c), 32'(bus.b_ready), (c == 4) ? 32'd1 : 32'd0);
         check($sformatf("starve_a_ready_c%0d", c), 32'(bus.a_ready), (c == 4) ? 32'd0 : 32'd1);
      end
      next_cycle();
      bus.b_valid = 1'b0;
      @(negedge clk);
      check("starve_wr_rd",   32'(bus.wr_rd), 32'd9);
      check("starve_wr_data", bus.wr_data, 32'h0000_0099);
      check("starve_a_resume", 32'(bus.a_ready), 32'd1);
      next_cycle();
      bus.a_valid = 1'b0;
      @(negedge clk);
      check("starve_a_wr_rd", 32'(bus.wr_rd), 32'd1);

      // scoreboard hazard on reg 12
      next_cycle();
      rs = 5'd12; rt = 5'd0; b_issue = 1'b1; b_issue_rd = 5'd12;
      @(negedge clk);
      check("sb_issue_cycle", 32'(hazard), 32'd0);
      next_cycle();
      b_issue = 1'b0;
      @(negedge clk);
      check("sb_busy1", 32'(hazard), 32'd1);
      next_cycle();
      @(negedge clk);
      check("sb_busy2", 32'(hazard), 32'd1);
      next_cycle();
      bus.b_valid = 1'b1; bus.b_rd = 5'd12; bus.b_data = 32'h0000_1234;
      @(negedge clk);
      check("sb_accept_ready",  32'(bus.b_ready), 32'd1);
      check("sb_accept_hazard", 32'(hazard), 32'd1);
      next_cycle();
      bus.b_valid = 1'b0;
      @(negedge clk);
      check("sb_inflight_hazard", 32'(hazard), FWD ? 32'd0 : 32'd1);
      check("sb_fwd_a_hit",       32'(fwd_a_hit), FWD ? 32'd1 : 32'd0);
      check("sb_fwd_b_hit",       32'(fwd_b_hit), 32'd0);
      check("sb_fwd_data",        fwd_data, FWD ? 32'h0000_1234 : 32'd0);
      next_cycle();
      @(negedge clk);
      check("sb_clear", 32'(hazard), 32'd0);

      // writes and issues to register 0
      next_cycle();
      rs = 5'd0; rt = 5'd0;
      bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'h5555_5555;
      @(negedge clk);
      check("r0_a_ready", 32'(bus.a_ready), 32'd1);
      next_cycle();
      bus.a_valid = 1'b0; b_issue = 1'b1; b_issue_rd = 5'd0;
      @(negedge clk);
      check("r0_wr_we", 32'(bus.wr_we), 32'd0);
      next_cycle();
      b_issue = 1'b0;
      @(negedge clk);
      check("r0_hazard", 32'(hazard), 32'd0);

      // issue and accept of reg 3 in the same cycle: busy stays set
      next_cycle();
      b_issue = 1'b1; b_issue_rd = 5'd3;
      bus.b_valid = 1'b1; bus.b_rd = 5'd3; bus.b_data = 32'h0000_0333;
      @(negedge clk);
      check("setclr_b_ready", 32'(bus.b_ready), 32'd1);
      next_cycle();
      b_issue = 1'b0; bus.b_valid = 1'b0; rs = 5'd3;
      @(negedge clk);
      check("setclr_wr_rd", 32'(bus.wr_rd), 32'd3);
      next_cycle();
      @(negedge clk);
      check("setclr_wr_we",  32'(bus.wr_we), 32'd0);
      check("setclr_hazard", 32'(hazard), 32'd1);

      // reset during a pending request
      next_cycle();
      rst = 1'b1;
      bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'h0000_0777;
      next_cycle();
      rst = 1'b0; bus.a_valid = 1'b0;
      @(negedge clk);
      check("rst2_wr_we",  32'(bus.wr_we), 32'd0);
      check("rst2_wr_rd",  32'(bus.wr_rd), 32'd0);
      check("rst2_hazard", 32'(hazard), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
